bram_ring_controller: RTL and testbench

BRAM_RING_CONTROLLER -- requirements
Module: bram_ring_controller

---
 rtl/bram_ring_controller.sv | 149 ++++++++++++++
 tb/tb_bram_ring_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_ring_controller.sv
// BRAM ring buffer flow controller: fill tracking, generator gating, irq.
// Optional stall watchdog compiled in with BRAM_RING_CTRL_WATCHDOG_EN.
module bram_ring_controller #(
    parameter int unsigned DEPTH_WORDS      = 16384,
    parameter int unsigned PKT_WORDS        = 144,
    parameter int unsigned IRQ_THRESH_WORDS = 4096,
    parameter int unsigned WDOG_CYCLES      = 1000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] wr_addr,
    input  logic        pkt_end,
    input  logic [13:0] rd_addr,
    input  logic        irq_ack,
    output logic        gen_enable,
    output logic        irq,
    output logic [13:0] fill_words,
    output logic [31:0] pkt_count,
    output logic [15:0] hold_count,
    output logic [1:0]  state,
    output logic        stall_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [13:0] AMASK   = 14'(DEPTH_WORDS - 1);
    localparam logic [31:0] FREE_MX = 32'(DEPTH_WORDS - 1);
    localparam logic [31:0] PKT1    = 32'(PKT_WORDS);
    localparam logic [31:0] PKT2    = 32'(2 * PKT_WORDS);
    localparam logic [31:0] THRESH  = 32'(IRQ_THRESH_WORDS);

    logic [1:0]  state_q, state_d;
    logic        gen_q, irq_q;
    logic [13:0] fill_q, fill_prev_q, fill_d;
    logic [31:0] pkt_q, free;
    logic [15:0] hold_q;
    logic        run_like, start_ok, wdog_fire, hold_entry;

    assign fill_d   = (wr_addr - rd_addr) & AMASK;
    assign free     = FREE_MX - {18'd0, fill_q};
    assign run_like = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign start_ok = (state_q == S_IDLE) && start && !stop;

    // Next-state decision; the watchdog overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start && !stop) state_d = S_RUN;
            S_RUN: begin
                if (stop)
                    state_d = S_FLUSH;
                else if (pkt_end && (free < PKT1))
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (stop)
                    state_d = S_IDLE;
                else if (free >= PKT2)
                    state_d = S_RUN;
            end
            S_FLUSH: if (pkt_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wdog_fire) state_d = S_IDLE;
    end

    assign hold_entry = (state_q == S_RUN) && (state_d == S_HOLD);

    // State, generator gate and packet/hold counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            gen_q   <= 1'b0;
            pkt_q   <= 32'd0;
            hold_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            gen_q   <= (state_d == S_RUN) || (state_d == S_FLUSH);
            if (start_ok)
                pkt_q <= 32'd0;
            else if (pkt_end && run_like)
                pkt_q <= pkt_q + 32'd1;
            if (start_ok)
                hold_q <= 16'd0;
            else if (hold_entry && (hold_q != 16'hFFFF))
                hold_q <= hold_q + 16'd1;
        end
    end

    // Fill level, its one-cycle history, and the threshold-crossing irq.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_q      <= 14'd0;
            fill_prev_q <= 14'd0;
            irq_q       <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            fill_prev_q <= fill_q;
            if (({18'd0, fill_q} >= THRESH) &&
                ({18'd0, fill_prev_q} < THRESH))
                irq_q <= 1'b1;
            else if (irq_ack)
                irq_q <= 1'b0;
        end
    end

`ifdef BRAM_RING_CTRL_WATCHDOG_EN
    logic [31:0] wdog_q;
    logic        stall_q;

    assign wdog_fire = run_like && !pkt_end &&
                       (wdog_q == 32'(WDOG_CYCLES - 1));

    // Stall watchdog: counts cycles since the last packet boundary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog_q  <= 32'd0;
            stall_q <= 1'b0;
        end else begin
            if (!run_like || pkt_end || wdog_fire)
                wdog_q <= 32'd0;
            else
                wdog_q <= wdog_q + 32'd1;
            if (start_ok)
                stall_q <= 1'b0;
            else if (wdog_fire)
                stall_q <= 1'b1;
        end
    end

    assign stall_err = stall_q;
`else
    assign wdog_fire = 1'b0;
    assign stall_err = 1'b0;
`endif

    assign gen_enable = gen_q;
    assign irq        = irq_q;
    assign fill_words = fill_q;
    assign pkt_count  = pkt_q;
    assign hold_count = hold_q;
    assign state      = state_q;

endmodule

// File: tb/tb_bram_ring_controller.sv
// Directed self-checking bench for bram_ring_controller.
// Watchdog steps run only when BRAM_RING_CTRL_WATCHDOG_EN is defined.
module tb_bram_ring_controller;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, stop, pkt_end, irq_ack;
    logic [13:0] wr_addr, rd_addr;
    logic        gen_enable, irq, stall_err;
    logic [13:0] fill_words;
    logic [31:0] pkt_count;
    logic [15:0] hold_count;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_ring_controller #(
        .DEPTH_WORDS(16384),
        .PKT_WORDS(144),
        .IRQ_THRESH_WORDS(4096),
        .WDOG_CYCLES(50)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .stop(stop),
        .wr_addr(wr_addr),
        .pkt_end(pkt_end),
        .rd_addr(rd_addr),
        .irq_ack(irq_ack),
        .gen_enable(gen_enable),
        .irq(irq),
        .fill_words(fill_words),
        .pkt_count(pkt_count),
        .hold_count(hold_count),
        .state(state),
        .stall_err(stall_err)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic pulse_pkt();
        pkt_end = 1'b1;
        tick();
        pkt_end = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pkt_end = 1'b0;
        irq_ack = 1'b0;
        wr_addr = 14'd0;
        rd_addr = 14'd0;
        tick(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gen", 32'(gen_enable), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_fill", 32'(fill_words), 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);
        chk("rst_hold", 32'(hold_count), 32'd0);
        chk("rst_stall", 32'(stall_err), 32'd0);
        rstn = 1'b1;
        tick();

        pulse_start();
        chk("start_state", 32'(state), 32'd1);
        chk("start_gen", 32'(gen_enable), 32'd1);

        for (int i = 0; i < 10; i++) begin
            wr_addr = wr_addr + 14'd144;
            rd_addr = wr_addr;
            pulse_pkt();
            tick();
        end
        chk("run10_state", 32'(state), 32'd1);
        chk("run10_pkt", pkt_count, 32'd10);
        chk("run10_fill", 32'(fill_words), 32'd0);
        chk("run10_irq", 32'(irq), 32'd0);

        rd_addr = 14'd0;
        wr_addr = 14'd4095;
        tick(2);
        chk("fill_4095", 32'(fill_words), 32'd4095);
        chk("irq_below", 32'(irq), 32'd0);
        wr_addr = 14'd4096;
        tick();
        chk("fill_4096", 32'(fill_words), 32'd4096);
        chk("irq_lag", 32'(irq), 32'd0);
        tick();
        chk("irq_rise", 32'(irq), 32'd1);
        pulse_ack();
        chk("irq_ack", 32'(irq), 32'd0);
        wr_addr = 14'd4000;
        tick(2);
        wr_addr = 14'd4100;
        tick();
        pulse_ack();
        chk("irq_set_wins", 32'(irq), 32'd1);
        pulse_ack();
        chk("irq_ack2", 32'(irq), 32'd0);

        wr_addr = 14'd100;
        rd_addr = 14'd16000;
        tick();
        chk("fill_wrap", 32'(fill_words), 32'd484);

        wr_addr = 14'd16300;
        rd_addr = 14'd0;
        tick();
        pulse_pkt();
        chk("hold_state", 32'(state), 32'd2);
        chk("hold_gen", 32'(gen_enable), 32'd0);
        chk("hold_cnt", 32'(hold_count), 32'd1);
        chk("hold_pkt", pkt_count, 32'd11);
        chk("hold_irq", 32'(irq), 32'd1);
        pulse_ack();
        pulse_pkt();
        chk("hold_pkt_ign", pkt_count, 32'd11);
        chk("hold_stay", 32'(state), 32'd2);
        rd_addr = 14'd16100;
        tick();
        chk("resume_lag", 32'(state), 32'd2);
        tick();
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_gen", 32'(gen_enable), 32'd1);

        pulse_start();
        chk("start_in_run", pkt_count, 32'd11);
        pulse_stop();
        chk("flush_state", 32'(state), 32'd3);
        chk("flush_gen", 32'(gen_enable), 32'd1);
        tick(3);
        chk("flush_hold_gen", 32'(gen_enable), 32'd1);
        pulse_pkt();
        chk("flush_idle", 32'(state), 32'd0);
        chk("flush_gen_off", 32'(gen_enable), 32'd0);
        chk("flush_pkt", pkt_count, 32'd12);

        pulse_stop();
        chk("stop_idle", 32'(state), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop", 32'(state), 32'd0);
        pulse_pkt();
        chk("idle_pkt_ign", pkt_count, 32'd12);

        pulse_start();
        chk("restart_pkt", pkt_count, 32'd0);
        chk("restart_hold", 32'(hold_count), 32'd0);
        rd_addr = 14'd0;
        tick();
        pulse_pkt();
        chk("hold2_state", 32'(state), 32'd2);
        pulse_stop();
        chk("hold_stop", 32'(state), 32'd0);
        chk("hold_stop_gen", 32'(gen_enable), 32'd0);
        pulse_ack();

        rd_addr = wr_addr;
        tick();
        pulse_start();
        pulse_pkt();
        tick(2);
        rstn = 1'b0;
        #2;
        chk("arst_gen", 32'(gen_enable), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_pkt", pkt_count, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

`ifdef BRAM_RING_CTRL_WATCHDOG_EN
        pulse_start();
        tick(49);
        chk("wd_pre_state", 32'(state), 32'd1);
        chk("wd_pre_stall", 32'(stall_err), 32'd0);
        tick();
        chk("wd_stall", 32'(stall_err), 32'd1);
        chk("wd_idle", 32'(state), 32'd0);
        pulse_start();
        chk("wd_clear", 32'(stall_err), 32'd0);
        chk("wd_restart", 32'(state), 32'd1);
`else
        pulse_start();
        tick(60);
        chk("nowd_stall", 32'(stall_err), 32'd0);
        chk("nowd_run", 32'(state), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
